// File: rtl/intr_deliver_pkg.sv
// Shared e1000 interrupt-delivery definitions: MSI FSM states, PCI register bit indices, widths.
// Combinational only, so it adds no latency and has no flow control.
// Pure type and constant package; it is imported by every file in this block.
package intr_deliver_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_LOW = 2'd2,
      HOLDOFF  = 2'd3
   } msi_state_t;

   localparam int INTX_DISABLE = 10;
   localparam int INTR_STATUS  = 3;
   localparam int MSI_DATA_W   = 16;

   // Bits needed to hold a count of 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/intr_holdoff_timer.sv
// Holdoff timer: holds at zero while load=1 and counts up while run=1, then stops at HOLDOFF_CYCLES-1.
// tc is combinational from the count, so it is high during the last of the HOLDOFF_CYCLES run cycles.
// Has no backpressure; run simply freezes the count once terminal count is reached.
module intr_holdoff_timer
   import intr_deliver_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load,
   input  logic run,
   output logic tc
);

   localparam int CW = cnt_width(HOLDOFF_CYCLES);
   localparam logic [CW-1:0] TC_VAL = CW'(HOLDOFF_CYCLES - 1);

   logic [CW-1:0] holdoff_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         holdoff_cnt <= '0;
      end else if (load) begin
         holdoff_cnt <= '0;
      end else if (run && !tc) begin
         holdoff_cnt <= holdoff_cnt + 1'b1;
      end
   end

   assign tc = (holdoff_cnt == TC_VAL);

endmodule

// File: rtl/intr_deliver.sv
// Turns the level intr_request into INTA#/Status[3] and, with INTR_DELIVER_MSI_EN, one MSI write per rising phase.
// INTA_n and intr_status follow one cycle after their inputs; msi_req rises one cycle after IDLE sees a request.
// msi_req holds address and data until msi_ack or msi_err; errors retry after holdoff, up to RETRY_MAX times.
module intr_deliver
   import intr_deliver_pkg::*;
#(
   parameter int RETRY_MAX      = 3,
   parameter int HOLDOFF_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  intr_request,
   input  logic                  cmd_intx_disable,
   input  logic                  msi_enable,
   input  logic [63:0]           msi_addr,
   input  logic [MSI_DATA_W-1:0] msi_data,
   output logic                  INTA_n,
   output logic                  intr_status,
   output logic                  msi_req,
   output logic [63:0]           msi_addr_o,
   output logic [31:0]           msi_data_o,
   input  logic                  msi_ack,
   input  logic                  msi_err,
   output logic                  msi_fail
);

   logic inta_assert;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         INTA_n      <= 1'b1;
         intr_status <= 1'b0;
      end else begin
         INTA_n      <= ~inta_assert;
         intr_status <= intr_request;
      end
   end

`ifdef INTR_DELIVER_MSI_EN

   localparam logic [3:0] RMAX = 4'(RETRY_MAX);

   msi_state_t state, next_state;
   logic [3:0] retry_cnt;
   logic       retry_ok, retry_pend, hold_tc, hold_load, hold_run;

   assign inta_assert = intr_request & ~cmd_intx_disable & ~msi_enable;
   assign retry_ok    = (retry_cnt < RMAX);
   // A nonzero retry count in HOLDOFF can only come from an errored attempt.
   assign retry_pend  = (retry_cnt != 4'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (msi_enable && intr_request) next_state = REQ;
         REQ:      if (msi_err)      next_state = retry_ok ? HOLDOFF : WAIT_LOW;
                   else if (msi_ack) next_state = WAIT_LOW;
         WAIT_LOW: if (!intr_request || !msi_enable) next_state = HOLDOFF;
         HOLDOFF:  if (hold_tc)
                      next_state = (retry_pend && intr_request && msi_enable) ? REQ : IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      msi_req   = (state == REQ);
      hold_run  = (state == HOLDOFF);
      hold_load = (state != HOLDOFF);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         retry_cnt  <= 4'd0;
         msi_fail   <= 1'b0;
         msi_addr_o <= '0;
         msi_data_o <= '0;
      end else begin
         msi_fail <= (state == REQ) && msi_err && !retry_ok;
         if (state == REQ && msi_err)
            retry_cnt <= retry_ok ? retry_cnt + 4'd1 : 4'd0;
         else if (state == REQ && msi_ack)
            retry_cnt <= 4'd0;
         else if (state == HOLDOFF && next_state == IDLE)
            retry_cnt <= 4'd0;
         if (next_state == REQ && state != REQ) begin
            msi_addr_o <= msi_addr;
            msi_data_o <= {{(32 - MSI_DATA_W){1'b0}}, msi_data};
         end
      end
   end

   intr_holdoff_timer #(
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
   ) u_holdoff (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .load  (hold_load),
      .run   (hold_run),
      .tc    (hold_tc)
   );

`else

   logic unused_ok;

   assign inta_assert = intr_request & ~cmd_intx_disable;
   assign msi_req     = 1'b0;
   assign msi_addr_o  = '0;
   assign msi_data_o  = '0;
   assign msi_fail    = 1'b0;
   assign unused_ok   = ^{msi_enable, msi_addr, msi_data, msi_ack, msi_err,
                          8'(RETRY_MAX), 8'(HOLDOFF_CYCLES)};

`endif

endmodule

// File: tb/tb_intr_deliver.sv
// Directed bench for intr_deliver: legacy INTx paths always, MSI handshake/retry/holdoff when INTR_DELIVER_MSI_EN is set.
module tb_intr_deliver;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        intr_request;
   logic        cmd_intx_disable;
   logic        msi_enable;
   logic [63:0] msi_addr;
   logic [15:0] msi_data;
   logic        INTA_n;
   logic        intr_status;
   logic        msi_req;
   logic [63:0] msi_addr_o;
   logic [31:0] msi_data_o;
   logic        msi_ack;
   logic        msi_err;
   logic        msi_fail;

   int total = 0;
   int bad   = 0;

   intr_deliver #(
      .RETRY_MAX      (3),
      .HOLDOFF_CYCLES (16)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .intr_request     (intr_request),
      .cmd_intx_disable (cmd_intx_disable),
      .msi_enable       (msi_enable),
      .msi_addr         (msi_addr),
      .msi_data         (msi_data),
      .INTA_n           (INTA_n),
      .intr_status      (intr_status),
      .msi_req          (msi_req),
      .msi_addr_o       (msi_addr_o),
      .msi_data_o       (msi_data_o),
      .msi_ack          (msi_ack),
      .msi_err          (msi_err),
      .msi_fail         (msi_fail)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_inta"},   64'(INTA_n),      64'd1);
      chk({tag, "_status"}, 64'(intr_status), 64'd0);
      chk({tag, "_req"},    64'(msi_req),     64'd0);
      chk({tag, "_addr"},   msi_addr_o,       64'd0);
      chk({tag, "_data"},   64'(msi_data_o),  64'd0);
      chk({tag, "_fail"},   64'(msi_fail),    64'd0);
   endtask

   // Counts msi_req-low cycles until msi_req rises, giving up after budget.
   task automatic wait_req(input int budget, output int lows);
      lows = 0;
      while (!msi_req && lows < budget) begin
         tick();
         lows++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "timeout");
   end

   initial begin
      int hi;
      int lows;
      int first;

      rst_i = 1'b1; intr_request = 1'b0; cmd_intx_disable = 1'b0; msi_enable = 1'b0;
      msi_addr = 64'd0; msi_data = 16'd0; msi_ack = 1'b0; msi_err = 1'b0;
      tick(); tick();
      chk_reset_outputs("reset");
      rst_i = 1'b0;
      tick();

      // Legacy INTx with MSI off
      intr_request = 1'b1;
      tick();
      chk("t1_inta_low",   64'(INTA_n), 64'd0);
      chk("t1_status_set", 64'(intr_status), 64'd1);
      cmd_intx_disable = 1'b1;
      tick();
      chk("t1_inta_disabled", 64'(INTA_n), 64'd1);
      chk("t1_status_kept",   64'(intr_status), 64'd1);
      intr_request = 1'b0; cmd_intx_disable = 1'b0;
      tick();
      chk("t1_inta_idle",   64'(INTA_n), 64'd1);
      chk("t1_status_clr",  64'(intr_status), 64'd0);

`ifdef INTR_DELIVER_MSI_EN
      // Single MSI, held request sends nothing more
      msi_enable = 1'b1; msi_addr = 64'h0000_0000_FEE0_0000; msi_data = 16'h4021;
      tick();
      intr_request = 1'b1;
      tick();
      chk("t2_req",  64'(msi_req), 64'd1);
      chk("t2_addr", msi_addr_o, 64'h0000_0000_FEE0_0000);
      chk("t2_data", 64'(msi_data_o), 64'h4021);
      chk("t2_inta", 64'(INTA_n), 64'd1);
      msi_addr = 64'h1234; msi_data = 16'hBEEF;
      tick(); tick();
      chk("t2_req_held",  64'(msi_req), 64'd1);
      chk("t2_addr_held", msi_addr_o, 64'h0000_0000_FEE0_0000);
      msi_ack = 1'b1;
      tick();
      msi_ack = 1'b0;
      chk("t2_req_drop", 64'(msi_req), 64'd0);
      hi = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (msi_req) hi++;
      end
      chk("t2_no_second", 64'(hi), 64'd0);

      // Drop, re-raise 5 cycles later: WAIT_LOW->HOLDOFF(16)->IDLE->REQ = 18 cycles from drop
      intr_request = 1'b0;
      first = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (msi_req && first < 0) first = i;
         if (i == 5) intr_request = 1'b1;
      end
      chk("t5_second_req_delay", 64'(first), 64'd18);
      chk("t5_new_addr", msi_addr_o, 64'h1234);
      msi_enable = 1'b0;
      tick(); tick(); tick();
      chk("t5_req_held_no_enable", 64'(msi_req), 64'd1);
      chk("t5_inta_legacy", 64'(INTA_n), 64'd0);
      msi_ack = 1'b1;
      tick();
      msi_ack = 1'b0;
      chk("t5_req_drop", 64'(msi_req), 64'd0);
      intr_request = 1'b0;
      for (int i = 0; i < 20; i++) tick();

      // Error on every attempt: 4 phases, 16 low cycles apart, then one msi_fail
      msi_enable = 1'b1; msi_addr = 64'h0000_0000_FEE0_0000; msi_data = 16'h4021;
      intr_request = 1'b1;
      for (int a = 0; a < 4; a++) begin
         wait_req(40, lows);
         chk($sformatf("t3_gap%0d", a), 64'(lows), (a == 0) ? 64'd1 : 64'd16);
         chk($sformatf("t3_req%0d", a), 64'(msi_req), 64'd1);
         msi_err = 1'b1;
         tick();
         msi_err = 1'b0;
         chk($sformatf("t3_drop%0d", a), 64'(msi_req), 64'd0);
         chk($sformatf("t3_fail%0d", a), 64'(msi_fail), (a == 3) ? 64'd1 : 64'd0);
      end
      tick();
      chk("t3_fail_pulse_end", 64'(msi_fail), 64'd0);
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (msi_req) hi++;
      end
      chk("t3_no_more_req", 64'(hi), 64'd0);

      // Simultaneous ack and err behaves as err: retry after holdoff
      intr_request = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      intr_request = 1'b1;
      tick();
      chk("t4_req", 64'(msi_req), 64'd1);
      msi_ack = 1'b1; msi_err = 1'b1;
      tick();
      msi_ack = 1'b0; msi_err = 1'b0;
      chk("t4_drop", 64'(msi_req), 64'd0);
      chk("t4_no_fail", 64'(msi_fail), 64'd0);
      wait_req(40, lows);
      chk("t4_retry_gap", 64'(lows), 64'd16);
      msi_ack = 1'b1;
      tick();
      msi_ack = 1'b0;
      chk("t4_ack_drop", 64'(msi_req), 64'd0);

      // Reset in the middle of a request
      intr_request = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      intr_request = 1'b1;
      tick();
      chk("t6_req", 64'(msi_req), 64'd1);
      rst_i = 1'b1;
      tick();
      chk_reset_outputs("t6_rst");
      rst_i = 1'b0;
`else
      // MSI not built: msi_enable ignored, MSI outputs stay zero
      msi_enable = 1'b1; msi_addr = 64'h0000_0000_FEE0_0000; msi_data = 16'h4021;
      intr_request = 1'b1;
      tick();
      chk("nomsi_inta_low", 64'(INTA_n), 64'd0);
      chk("nomsi_status",   64'(intr_status), 64'd1);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         msi_ack = i[0]; msi_err = i[1];
         tick();
         if (msi_req || msi_fail || msi_addr_o != 64'd0 || msi_data_o != 32'd0) hi++;
      end
      msi_ack = 1'b0; msi_err = 1'b0;
      chk("nomsi_outputs_zero", 64'(hi), 64'd0);
      chk("nomsi_inta_held", 64'(INTA_n), 64'd0);
      intr_request = 1'b0;
      tick();
      chk("nomsi_inta_release", 64'(INTA_n), 64'd1);
      intr_request = 1'b1; rst_i = 1'b1;
      tick();
      chk_reset_outputs("nomsi_rst");
      rst_i = 1'b0;
`endif

      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
